// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register front-end: FSM states, control-register
// field positions and the host-writable mask.
package spi_regs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SEND_BIT = 0;
  localparam int CS_BIT   = 1;
  localparam int ALL1_BIT = 2;
  localparam int ALL0_BIT = 3;
  localparam int NTX_LSB  = 4;
  localparam int NTX_MSB  = 12;
  localparam int NRX_LSB  = 16;
  localparam int NRX_MSB  = 25;

  localparam int NTX_W = NTX_MSB - NTX_LSB + 1;
  localparam int NRX_W = NRX_MSB - NRX_LSB + 1;

  // Bits a host write may set: send, the three pass-through flags and n_tx_end.
  // n_rx_end is status owned by the FSM and always restarts from zero on a write.
  localparam logic [31:0] CTRL_WR_MASK =
      (32'h1 << SEND_BIT) | (32'h1 << CS_BIT) | (32'h1 << ALL1_BIT) |
      (32'h1 << ALL0_BIT) | (((32'h1 << NTX_W) - 32'h1) << NTX_LSB);

  // Received-word counter increment that sticks at its maximum value.
  function automatic logic [NRX_W-1:0] nrx_sat_inc(input logic [NRX_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fsm_regcontrol_core.sv
// Transaction FSM, transferred-word counter and control-register update.
// Inputs are already single-cycle edge pulses from the top level.
module fsm_regcontrol_core
  import spi_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_ctrl,
  input  logic        trans_edge,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl
);

  state_t           state;
  state_t           state_nxt;
  logic [NTX_W-1:0] tx_cnt;
  logic             load_ctrl;
  logic             count_word;
  logic             clear_send;
  logic             start_tx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle action decode; host control writes only land in IDLE,
  // so a write coinciding with a transfer event in BUSY is simply not decoded.
  always_comb begin
    state_nxt  = state;
    load_ctrl  = 1'b0;
    count_word = 1'b0;
    clear_send = 1'b0;
    start_tx   = 1'b0;
    case (state)
      IDLE: begin
        load_ctrl = wr_ctrl;
        if (ctrl[SEND_BIT]) begin
          start_tx  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (trans_edge) begin
          count_word = 1'b1;
          if (tx_cnt == ctrl[NTX_MSB:NTX_LSB]) state_nxt = DONE;
        end
      end
      DONE: begin
        clear_send = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Words transferred in the current transaction; restarts when a transaction begins.
  always_ff @(posedge clk) begin
    if (rst)             tx_cnt <= '0;
    else if (start_tx)   tx_cnt <= '0;
    else if (count_word) tx_cnt <= tx_cnt + 1'b1;
  end

  // Control register: host load, received-word count, and send clear on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (load_ctrl) begin
      ctrl <= wdata & CTRL_WR_MASK;
    end else if (count_word) begin
      ctrl[NRX_MSB:NRX_LSB] <= nrx_sat_inc(ctrl[NRX_MSB:NRX_LSB]);
    end else if (clear_send) begin
      ctrl[SEND_BIT] <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_regcontrol_top.sv
// SPI register front-end: edge detection of host and engine strobes, the data
// buffer with its wrapping write pointer, and the host readback mux.
module fsm_regcontrol_top
  import spi_regs_pkg::*;
#(
  parameter int N = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic        reg_sel_i,
  input  logic [31:0] entrada_i,
  input  logic        t_trans_ready,
  output logic [31:0] salida_o
);

  localparam int DEPTH = 1 << N;

  logic          wr_q;
  logic          ttr_q;
  logic          wr_edge;
  logic          ttr_edge;
  logic [N-1:0]  wr_ptr;
  logic [N-1:0]  rd_ptr;
  logic [31:0]   ctrl;
  logic [31:0]   mem [0:DEPTH-1];

  // Delayed copies of the level strobes so a held level acts only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      ttr_q <= 1'b0;
    end else begin
      wr_q  <= wr_i;
      ttr_q <= t_trans_ready;
    end
  end

  assign wr_edge  = wr_i & ~wr_q;
  assign ttr_edge = t_trans_ready & ~ttr_q;

  // Data buffer: accepts host data writes in every FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_edge && !reg_sel_i) begin
      mem[wr_ptr] <= entrada_i;
    end
  end

  // Write pointer, wrapping naturally at the buffer depth.
  always_ff @(posedge clk) begin
    if (rst)                         wr_ptr <= '0;
    else if (wr_edge && !reg_sel_i)  wr_ptr <= wr_ptr + 1'b1;
  end

  fsm_regcontrol_core u_core (
    .clk        (clk),
    .rst        (rst),
    .wr_ctrl    (wr_edge & reg_sel_i),
    .trans_edge (ttr_edge),
    .wdata      (entrada_i),
    .ctrl       (ctrl)
  );

  // Readback shows the most recently written data word.
  assign rd_ptr   = wr_ptr - N'(1);
  assign salida_o = reg_sel_i ? ctrl : mem[rd_ptr];

endmodule

// File: tb/tb_fsm_regcontrol_top.sv
// Bench for fsm_regcontrol_top: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a transaction-level reference model.
module tb_fsm_regcontrol_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic        sel;
  logic [31:0] din;
  logic        ttr;
  logic [31:0] salida;

  int n_cmp = 0;
  int n_bad = 0;

  fsm_regcontrol_top #(.N(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_i          (wr),
    .reg_sel_i     (sel),
    .entrada_i     (din),
    .t_trans_ready (ttr),
    .salida_o      (salida)
  );

  always #5 clk = ~clk;

  // Reference model: control word, buffer contents, and how many words the
  // running transaction still needs (0 = none running).
  logic [31:0] m_ctrl;
  logic [31:0] m_mem [32];
  int          m_ptr;
  logic        m_wr_q, m_ttr_q;
  int          m_left;
  bit          m_fin;

  task automatic model_reset();
    m_ctrl = 0; m_ptr = 0; m_wr_q = 0; m_ttr_q = 0; m_left = 0; m_fin = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
  endtask

  task automatic model_step();
    bit we, te, start;
    int nrx;
    we = wr && !m_wr_q;
    te = ttr && !m_ttr_q;
    if (rst) begin
      model_reset();
      return;
    end
    m_wr_q  = wr;
    m_ttr_q = ttr;
    if (we && !sel) begin
      m_mem[m_ptr] = din;
      m_ptr = (m_ptr + 1) % 32;
    end
    if (m_fin) begin
      m_ctrl[0] = 1'b0;
      m_fin = 0;
    end else if (m_left > 0) begin
      if (te) begin
        nrx = int'(m_ctrl[25:16]);
        if (nrx < 1023) nrx++;
        m_ctrl[25:16] = nrx[9:0];
        m_left--;
        if (m_left == 0) m_fin = 1;
      end
    end else begin
      start = m_ctrl[0];
      if (we && sel) m_ctrl = din & 32'h0000_1FFF;
      if (start) m_left = int'(m_ctrl[12:4]) + 1;
    end
  endtask

  function automatic logic [31:0] model_out();
    return sel ? m_ctrl : m_mem[(m_ptr + 31) % 32];
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic w, input logic s, input logic t,
                        input logic [31:0] d);
    rst = r; wr = w; sel = s; ttr = t; din = d;
  endtask

  task automatic pulse_wr(input logic s, input logic [31:0] d);
    set_in(0, 1, s, 0, d); cyc();
    set_in(0, 0, s, 0, d); cyc();
  endtask

  task automatic pulse_ttr();
    ttr = 1; cyc();
    ttr = 0; cyc();
  endtask

  typedef struct {
    logic        rst;
    logic        wr;
    logic        sel;
    logic        ttr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[16];

  initial begin
    model_reset();
    set_in(1, 0, 1, 0, 0);

    tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1,        32'h1};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1,        32'h1};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1,        32'h1};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0001_0001};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0001_0000};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0001_0000};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1,        32'h1};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD,     32'h1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0001_0000};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h1};
    tv[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0001_0000};
    tv[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0001_0000};
    tv[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_1FFE};
    tv[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_1FFE};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      set_in(tv[i].rst, tv[i].wr, tv[i].sel, tv[i].ttr, tv[i].din);
      cyc();
      check($sformatf("vec%0d", i), salida, tv[i].exp);
    end

    // Buffer wrap: 33 writes from an empty pointer overwrite word 0.
    set_in(1, 0, 0, 0, 0); cyc();
    check("wrap_rst", salida, 32'h0);
    for (int i = 0; i < 33; i++) begin
      pulse_wr(0, 32'h100 + i);
      if (i == 31) check("wrap_last_word", salida, 32'h11F);
    end
    check("wrap_word0", salida, 32'h120);

    // Four-word transaction; control write while busy is dropped.
    pulse_wr(1, 32'h31);
    check("tx4_start", salida, 32'h31);
    for (int i = 0; i < 3; i++) pulse_ttr();
    check("tx4_three", salida, 32'h0003_0031);
    pulse_wr(1, 32'hFFFF_FFFF);
    check("tx4_wr_busy", salida, 32'h0003_0031);
    pulse_ttr();
    check("tx4_done", salida, 32'h0004_0030);
    cyc();
    check("tx4_idle", salida, 32'h0004_0030);

    // Control write edge coinciding with a transfer edge in BUSY.
    pulse_wr(1, 32'h21);
    set_in(0, 1, 1, 1, 32'h5); cyc();
    check("coll_count", salida, 32'h0001_0021);
    set_in(0, 0, 1, 0, 32'h5); cyc();
    pulse_ttr();
    pulse_ttr();
    check("coll_done", salida, 32'h0003_0020);

    // Reset mid-transaction.
    pulse_wr(1, 32'h31);
    pulse_ttr();
    check("rstb_busy", salida, 32'h0001_0031);
    set_in(1, 0, 1, 0, 0); cyc();
    check("rstb_ctrl", salida, 32'h0);
    rst = 0;
    pulse_ttr();
    pulse_ttr();
    check("rstb_ttr", salida, 32'h0);
    sel = 0; cyc();
    check("rstb_data", salida, 32'h0);
    pulse_wr(1, 32'hF0);
    check("rstb_idle_wr", salida, 32'hF0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic s;
      logic [31:0] d;
      s = $urandom_range(0, 1) == 1;
      if (s) d = {$urandom_range(0, 15) == 0 ? 32'hFFFF_E000 : 32'h0} |
                 {23'h0, 6'($urandom_range(0, 5)), 3'($urandom_range(0, 7))} |
                 {31'h0, 1'($urandom_range(0, 1))};
      else   d = $urandom;
      set_in($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, s,
             $urandom_range(0, 1) == 1, d);
      cyc();
      check($sformatf("rand%0d", i), salida, model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
